// File: rtl/sha256_stream_hasher.sv
// SHA-256 hasher for a word-aligned message of runtime length, read from a
// synchronous word memory. Padding is generated per block while loading, and an
// optional second pass hashes the first digest. The 8-word digest is then written
// back to memory.
module sha256_stream_hasher #(
    parameter int MAX_WORDS = 64,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              double_hash,
    input  logic [12:0]       num_words,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [ADDR_W-1:0] output_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data,
    output logic [2:0]        state
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_UPDATE  = 3'd4;
    localparam logic [2:0] S_PASS2   = 3'd5;
    localparam logic [2:0] S_WRITE   = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
        return (x >> s) | (x << (32 - s));
    endfunction

    // Latched request
    logic [12:0]       n_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [ADDR_W-1:0] oaddr_q;
    logic              dbl_q;
    logic              rej_q;

    // Sequencing: nb = blocks in this pass, blk = current block, cnt = step in phase
    logic [8:0] nb;
    logic [8:0] blk;
    logic [8:0] blk_next;
    logic [5:0] cnt;

    // Chaining value, working registers a..h as v[0..7], rolling schedule window
    logic [31:0] h [0:7];
    logic [31:0] v [0:7];
    logic [31:0] w [0:15];

    // g_cur: index whose address is presented now; g_prev: index whose data arrives now
    logic [13:0] g_cur;
    logic [13:0] g_prev;
    logic [13:0] g_last;
    logic [31:0] load_word;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] w_next;

    assign g_cur    = {1'b0, blk, 4'b0} + {8'b0, cnt};
    assign g_prev   = g_cur - 14'd1;
    assign g_last   = {1'b0, nb, 4'b0} - 14'd1;
    assign blk_next = blk + 9'd1;

    assign mem_clk = clk;
    assign busy    = (state != S_IDLE) && (state != S_DONE);
    assign done    = (state == S_DONE);
    assign err     = (state == S_DONE) && rej_q;
    assign mem_we  = (state == S_WRITE);

    // Message word or on-the-fly padding word for the slot whose read data is arriving
    always_comb begin
        load_word = 32'h0;
        if (g_prev < {1'b0, n_q})       load_word = mem_read_data;
        else if (g_prev == {1'b0, n_q}) load_word = 32'h8000_0000;
        else if (g_prev == g_last)      load_word = {14'b0, n_q, 5'b0};
    end

    // One compression round and the next schedule word
    always_comb begin
        t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                  + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[cnt] + w[0];
        t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        w_next = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
               + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
    end

    // Memory address/data: reads only for real message words, writes during WRITE
    always_comb begin
        mem_addr       = '0;
        mem_write_data = 32'h0;
        if (state == S_LOAD && cnt < 6'd16 && g_cur < {1'b0, n_q}) begin
            mem_addr = maddr_q + ADDR_W'(g_cur);
        end else if (state == S_WRITE) begin
            mem_addr       = oaddr_q + ADDR_W'(cnt[2:0]);
            mem_write_data = h[cnt[2:0]];
        end
    end

    // Control FSM and request latching
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 6'd0;
            blk     <= 9'd0;
            nb      <= 9'd0;
            n_q     <= 13'd0;
            maddr_q <= '0;
            oaddr_q <= '0;
            dbl_q   <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    if (num_words > 13'(MAX_WORDS)) begin
                        rej_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        rej_q   <= 1'b0;
                        n_q     <= num_words;
                        maddr_q <= message_addr;
                        oaddr_q <= output_addr;
                        dbl_q   <= double_hash;
                        state   <= S_INIT;
                    end
                end
                S_INIT: begin
                    blk   <= 9'd0;
                    nb    <= 9'(({1'b0, n_q} + 14'd18) >> 4);
                    cnt   <= 6'd0;
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    cnt <= (cnt == 6'd16) ? 6'd0 : cnt + 6'd1;
                    if (cnt == 6'd16) state <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd63) state <= S_UPDATE;
                end
                S_UPDATE: begin
                    cnt <= 6'd0;
                    blk <= blk_next;
                    if (blk_next < nb) state <= S_LOAD;
                    else if (dbl_q)    state <= S_PASS2;
                    else               state <= S_WRITE;
                end
                S_PASS2: begin
                    nb    <= 9'd1;
                    blk   <= 9'd0;
                    dbl_q <= 1'b0;
                    cnt   <= 6'd0;
                    state <= S_COMPUTE;
                end
                S_WRITE: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd7) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Hash datapath: chaining value, working registers and schedule window
    always_ff @(posedge clk) begin
        case (state)
            S_INIT: for (int i = 0; i < 8; i++) h[i] <= IV[i];
            S_LOAD: begin
                if (cnt != 6'd0) w[cnt[3:0] - 4'd1] <= load_word;
                if (cnt == 6'd16) for (int i = 0; i < 8; i++) v[i] <= h[i];
            end
            S_COMPUTE: begin
                v[0] <= t1 + t2;
                v[1] <= v[0];
                v[2] <= v[1];
                v[3] <= v[2];
                v[4] <= v[3] + t1;
                v[5] <= v[4];
                v[6] <= v[5];
                v[7] <= v[6];
                for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                w[15] <= w_next;
            end
            S_UPDATE: for (int i = 0; i < 8; i++) h[i] <= h[i] + v[i];
            S_PASS2: begin
                for (int i = 0; i < 8; i++) begin
                    w[i] <= h[i];
                    h[i] <= IV[i];
                    v[i] <= IV[i];
                end
                w[8] <= 32'h8000_0000;
                for (int i = 9; i < 15; i++) w[i] <= 32'h0;
                w[15] <= 32'h0000_0100;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sha256_stream_hasher.sv
// Bench for sha256_stream_hasher: a table of requests checked against constant
// digests or an independent SHA-256 reference, plus reset-abort and busy-start cases.
module tb_sha256_stream_hasher;
    localparam int ADDR_W    = 16;
    localparam int MAX_WORDS = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              double_hash;
    logic [12:0]       num_words;
    logic [ADDR_W-1:0] message_addr;
    logic [ADDR_W-1:0] output_addr;
    logic              busy;
    logic              done;
    logic              err;
    logic              mem_clk;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;
    logic [2:0]        state;

    sha256_stream_hasher #(.MAX_WORDS(MAX_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .double_hash(double_hash),
        .num_words(num_words), .message_addr(message_addr), .output_addr(output_addr),
        .busy(busy), .done(done), .err(err), .mem_clk(mem_clk), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .state(state));

    // Clock
    always #5 clk = ~clk;

    // Synchronous-read word memory; digest writes are captured by the bench instead
    logic [31:0] mem [0:1023];
    bit          rd_seen [0:1023];
    always @(posedge clk) mem_read_data <= mem[mem_addr[9:0]];

    int tests = 0;
    int fails = 0;

    localparam logic [255:0] IV_P = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [31:0] K_TB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef struct {
        int           n;
        bit           dbl;
        int           maddr;
        int           oaddr;
        bit           use_model;
        logic [255:0] exp;
        int           poke;
    } vec_t;

    vec_t vecs [0:9];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
        return (x >> s) | (x << (32 - s));
    endfunction

    // Reference compression with the full 64-entry schedule
    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  ws [0:63];
        logic [31:0]  a, b, c, d, e, f, g, hh, t1, t2;
        logic [255:0] s;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) ws[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            ws[t] = (rotr(ws[t-2], 17) ^ rotr(ws[t-2], 19) ^ (ws[t-2] >> 10)) + ws[t-7]
                  + (rotr(ws[t-15], 7) ^ rotr(ws[t-15], 18) ^ (ws[t-15] >> 3)) + ws[t-16];
        {a, b, c, d, e, f, g, hh} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K_TB[t] + ws[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        s = {a, b, c, d, e, f, g, hh};
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + s[255-32*i -: 32];
        return r;
    endfunction

    // Reference hash of n words at mem[base..], standard padding with 64-bit bit length
    function automatic logic [255:0] model_hash(input int n, input int base, input bit dbl);
        int           nblk;
        int           gi;
        logic [255:0] hv;
        logic [511:0] blk;
        logic [31:0]  wd;
        nblk = (n * 32 + 1 + 64 + 511) / 512;
        hv = IV_P;
        for (int bi = 0; bi < nblk; bi++) begin
            for (int s = 0; s < 16; s++) begin
                gi = 16 * bi + s;
                if (gi < n)                 wd = mem[10'(base + gi)];
                else if (gi == n)           wd = 32'h8000_0000;
                else if (gi == 16*nblk - 1) wd = 32'(n * 32);
                else                        wd = 32'h0;
                blk[511-32*s -: 32] = wd;
            end
            hv = compress(hv, blk);
        end
        if (dbl) hv = compress(IV_P, {hv, 32'h8000_0000, 192'h0, 32'h0000_0100});
        return hv;
    endfunction

    task automatic check_v(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Driver + monitor for one request; scoreboard compares written digest words
    task automatic run_vec(input int idx, input vec_t v);
        logic [255:0]      exp_dig;
        logic [31:0]       exp_q [$];
        logic [ADDR_W-1:0] wa [$];
        logic [31:0]       wd [$];
        logic [31:0]       e;
        int  lat, exp_lat, nblk, extra, addr_bad, rd_bad;
        bit  rej, saw_done, got_err, got_busy;
        rej = v.n > MAX_WORDS;
        for (int i = 0; i < v.n && i < 100; i++)
            mem[10'(v.maddr + i)] = (v.n == 1 && !v.use_model) ? 32'h6162_6364 : $urandom;
        exp_dig = v.use_model ? model_hash(v.n, v.maddr, v.dbl) : v.exp;
        nblk    = (v.n + 3 + 15) / 16;
        exp_lat = rej ? 1 : (2 + 82 * nblk + 8 + (v.dbl ? 66 : 0));
        for (int i = 0; i < 1024; i++) rd_seen[i] = 1'b0;
        got_err  = 1'b0;
        got_busy = 1'b0;
        saw_done = 1'b0;
        lat      = 0;
        @(posedge clk); #1;
        start        = 1'b1;
        double_hash  = v.dbl;
        num_words    = 13'(v.n);
        message_addr = ADDR_W'(v.maddr);
        output_addr  = ADDR_W'(v.oaddr);
        while (!saw_done && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) start = 1'b0;
            if (v.poke != 0 && lat == v.poke) begin
                start = 1'b1; num_words = 13'd0; double_hash = 1'b0; output_addr = ADDR_W'(900);
            end
            if (v.poke != 0 && lat == v.poke + 1) start = 1'b0;
            if (state == 3'd2) rd_seen[mem_addr[9:0]] = 1'b1;
            if (mem_we) begin
                wa.push_back(mem_addr);
                wd.push_back(mem_write_data);
            end
            if (done) begin
                saw_done = 1'b1;
                got_err  = err;
                got_busy = busy;
            end
        end
        check_i($sformatf("v%0d done seen", idx), int'(saw_done), 1);
        check_i($sformatf("v%0d latency", idx), lat, exp_lat);
        check_i($sformatf("v%0d err", idx), int'(got_err), int'(rej));
        check_i($sformatf("v%0d busy at done", idx), int'(got_busy), 0);
        check_i($sformatf("v%0d write count", idx), wa.size(), rej ? 0 : 8);
        if (!rej) begin
            for (int k = 0; k < 8; k++) exp_q.push_back(exp_dig[255-32*k -: 32]);
            addr_bad = 0;
            for (int k = 0; k < 8 && k < wd.size(); k++) begin
                e = exp_q.pop_front();
                check_v($sformatf("v%0d digest word %0d", idx, k), 256'(wd[k]), 256'(e));
                if (wa[k] !== ADDR_W'(v.oaddr + k)) addr_bad++;
            end
            check_i($sformatf("v%0d write addresses", idx), addr_bad, 0);
        end
        rd_bad = 0;
        for (int i = 0; i < v.n + 32 && i < 100; i++)
            if (rd_seen[10'(v.maddr + i)] != (!rej && i < v.n)) rd_bad++;
        check_i($sformatf("v%0d read coverage", idx), rd_bad, 0);
        extra = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (busy || done || mem_we) extra++;
        end
        check_i($sformatf("v%0d idle after done", idx), extra, 0);
    endtask

    initial begin
        vec_t rv;
        int   lat, bad;
        vecs[0] = '{0,  1'b0, 100, 600, 1'b0, 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855, 0};
        vecs[1] = '{1,  1'b0, 110, 610, 1'b0, 256'h88d4266f_d4e6338d_13b845fc_f289579d_209c8978_23b9217d_a3e16193_6f031589, 0};
        vecs[2] = '{0,  1'b1, 120, 620, 1'b0, 256'h5df6e0e2_761359d3_0a827505_8e299fcc_03815345_45f55cf4_3e41983f_5d4c9456, 0};
        vecs[3] = '{13, 1'b0, 130, 630, 1'b1, 256'h0, 0};
        vecs[4] = '{14, 1'b0, 150, 640, 1'b1, 256'h0, 0};
        vecs[5] = '{20, 1'b0, 180, 650, 1'b1, 256'h0, 0};
        vecs[6] = '{20, 1'b1, 210, 660, 1'b1, 256'h0, 0};
        vecs[7] = '{64, 1'b0, 240, 670, 1'b1, 256'h0, 0};
        vecs[8] = '{13, 1'b0, 320, 680, 1'b1, 256'h0, 30};
        vecs[9] = '{65, 1'b0, 400, 690, 1'b0, 256'h0, 0};

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        // Reset state
        reset = 1'b1; start = 1'b0; double_hash = 1'b0; num_words = 13'd0;
        message_addr = '0; output_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_i("reset state", int'(state), 0);
        check_i("reset outputs", int'({busy, done, err, mem_we}), 0);
        check_i("reset mem_addr", int'(mem_addr), 0);
        check_i("reset mem_write_data", int'(mem_write_data), 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Reset during round 40 of the first COMPUTE phase
        for (int i = 0; i < 14; i++) mem[200 + i] = $urandom;
        @(posedge clk); #1;
        start = 1'b1; double_hash = 1'b0; num_words = 13'd14;
        message_addr = ADDR_W'(200); output_addr = ADDR_W'(700);
        lat = 0;
        bad = 0;
        repeat (60) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) start = 1'b0;
            if (done || mem_we) bad++;
            if (lat == 59) begin
                check_i("rst: in COMPUTE", int'(state), 3);
                reset = 1'b1;
            end
        end
        check_i("rst: state after", int'(state), 0);
        check_i("rst: busy/we/done after", int'({busy, mem_we, done}), 0);
        reset = 1'b0;
        repeat (200) begin
            @(posedge clk); #1;
            if (done || mem_we || busy) bad++;
        end
        check_i("rst: no activity", bad, 0);
        rv = '{14, 1'b0, 220, 710, 1'b1, 256'h0, 0};
        run_vec(10, rv);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
